counter_sequencer: RTL and testbench

Controller that sequences an 8-bit counter datapath: start, pause, resume and clear, with a programmable terminal count, prescaler and one-shot/auto-reload modes. Commands arrive over a valid/ready interface from the control logic. Status goes back to the same logic as a done pulse, busy flag, saturating wrap count and error pulse. Fully synchronous replacement for the free-running ripple chain, used where counting must be gated and bounded.

---
 rtl/counter_sequencer_if.sv | 34 +++
 rtl/counter_sequencer.sv | 141 ++++++++++++++
 tb/tb_counter_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Command/config/status bundle between control logic and counter_sequencer.
// Latency: none; it only groups wires.
// Backpressure: cmd_ready qualifies cmd_valid; status signals have no flow control.
// Signals:
//   master (control logic) drives cmd_valid, cmd_op, cfg_limit, cfg_reload and cfg_prescale.
//   slave (sequencer) drives cmd_ready, q, busy, done, wrap_cnt, cmd_err and state.
interface counter_sequencer_if #(
   parameter int WIDTH  = 8,
   parameter int PRE_W  = 4,
   parameter int WRAP_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [WIDTH-1:0]  cfg_limit;
   logic              cfg_reload;
   logic [PRE_W-1:0]  cfg_prescale;
   logic [WIDTH-1:0]  q;
   logic              busy;
   logic              done;
   logic [WRAP_W-1:0] wrap_cnt;
   logic              cmd_err;
   logic [1:0]        state;

   modport master (
      output cmd_valid, cmd_op, cfg_limit, cfg_reload, cfg_prescale,
      input  cmd_ready, q, busy, done, wrap_cnt, cmd_err, state
   );

   modport slave (
      input  cmd_valid, cmd_op, cfg_limit, cfg_reload, cfg_prescale,
      output cmd_ready, q, busy, done, wrap_cnt, cmd_err, state
   );
endinterface

// File: rtl/counter_sequencer.sv
// Gated, bounded 8-bit counter with start/pause/resume/clear, prescaler and one-shot/reload.
// Latency: an accepted command or a tick is visible on the outputs one cycle after its edge.
// Backpressure: cmd_ready is high in every cycle that follows a non-reset edge; commands are never stalled.
// Ports:
//   clk, reset    rising-edge clock and synchronous active-high reset
//   bus (slave)   command and config inputs; q, busy, done, wrap_cnt, cmd_err and state outputs, all registered
module counter_sequencer #(
   parameter int WIDTH  = 8,
   parameter int PRE_W  = 4,
   parameter int WRAP_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   counter_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_PAUSE  = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   state_t            state_q;
   logic [WIDTH-1:0]  q_q;
   logic [WIDTH-1:0]  limit_q;
   logic [PRE_W-1:0]  pc_q;
   logic [PRE_W-1:0]  pre_q;
   logic              reload_q;
   logic [WRAP_W-1:0] wrap_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              rdy_q;

   logic cmd_acc;
   logic cmd_hit;
   logic cmd_bad;
   logic tick;
   logic at_limit;
   logic wrap_sat;

   assign cmd_acc  = bus.cmd_valid && rdy_q;

   // START and CLEAR are legal everywhere; PAUSE only from RUN, RESUME only from PAUSE.
   assign cmd_hit  = cmd_acc &&
                     ((bus.cmd_op == OP_START) || (bus.cmd_op == OP_CLEAR) ||
                      ((bus.cmd_op == OP_PAUSE)  && (state_q == S_RUN)) ||
                      ((bus.cmd_op == OP_RESUME) && (state_q == S_PAUSE)));
   assign cmd_bad  = cmd_acc && !cmd_hit;

   assign tick     = (state_q == S_RUN) && (pc_q == pre_q);
   // Compare before increment, so limit = all-ones never overflows q.
   assign at_limit = (q_q == limit_q);
   assign wrap_sat = &wrap_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         q_q      <= '0;
         limit_q  <= '0;
         pc_q     <= '0;
         pre_q    <= '0;
         reload_q <= 1'b0;
         wrap_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdy_q    <= 1'b0;
      end else begin
         rdy_q  <= 1'b1;
         done_q <= 1'b0;
         err_q  <= cmd_bad;
         // A legal command owns this edge: any coincident tick is dropped, not deferred.
         // An illegal command changes nothing, so counting carries on underneath it.
         if (cmd_hit) begin
            case (bus.cmd_op)
               OP_START: begin
                  limit_q  <= bus.cfg_limit;
                  reload_q <= bus.cfg_reload;
                  pre_q    <= bus.cfg_prescale;
                  q_q      <= '0;
                  pc_q     <= '0;
                  wrap_q   <= '0;
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
               end
               OP_PAUSE: begin
                  state_q <= S_PAUSE;
                  busy_q  <= 1'b1;
               end
               OP_RESUME: begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end
               default: begin
                  q_q     <= '0;
                  pc_q    <= '0;
                  wrap_q  <= '0;
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end else if (state_q == S_RUN) begin
            if (tick) begin
               pc_q <= '0;
               if (!at_limit) begin
                  q_q <= q_q + 1'b1;
               end else begin
                  done_q <= 1'b1;
                  if (reload_q) begin
                     q_q <= '0;
                     if (!wrap_sat) begin
                        wrap_q <= wrap_q + 1'b1;
                     end
                  end else begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                  end
               end
            end else begin
               pc_q <= pc_q + 1'b1;
            end
         end
      end
   end

   assign bus.cmd_ready = rdy_q;
   assign bus.q         = q_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.wrap_cnt  = wrap_q;
   assign bus.cmd_err   = err_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios, then random commands against a reference model.
// The model tracks elapsed counting cycles and derives q, wraps and done arithmetically.
// Inputs are driven and outputs are compared on the falling edge.
module tb_counter_sequencer;

   localparam logic [1:0] OP_START  = 2'b00;
   localparam logic [1:0] OP_PAUSE  = 2'b01;
   localparam logic [1:0] OP_RESUME = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   counter_sequencer_if #(.WIDTH(8), .PRE_W(4), .WRAP_W(8)) bus ();

   counter_sequencer #(.WIDTH(8), .PRE_W(4), .WRAP_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model state: elapsed counting cycles since START plus the latched config.
   int m_st   = M_IDLE;
   int m_e    = 0;
   int m_lim  = 0;
   int m_pre  = 0;
   int m_rel  = 0;
   bit m_rdy  = 1'b0;
   bit m_done = 1'b0;
   bit m_err  = 1'b0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model across the rising edge, then compare everything.
   task automatic step(input bit rst, input bit vld, input logic [1:0] op,
                       input int lim, input int rel, input int pre);
      bit acc;
      bit eff;
      int t;
      int eq;
      int ew;
      reset            = rst;
      bus.cmd_valid    = vld;
      bus.cmd_op       = op;
      bus.cfg_limit    = lim[7:0];
      bus.cfg_reload   = rel[0];
      bus.cfg_prescale = pre[3:0];

      m_done = 1'b0;
      m_err  = 1'b0;
      if (rst) begin
         m_st  = M_IDLE;
         m_e   = 0;
         m_lim = 0;
         m_pre = 0;
         m_rel = 0;
         m_rdy = 1'b0;
      end else begin
         acc = vld && m_rdy;
         eff = acc && ((op == OP_START) || (op == OP_CLEAR) ||
                       ((op == OP_PAUSE) && (m_st == M_RUN)) ||
                       ((op == OP_RESUME) && (m_st == M_PAUSE)));
         m_err = acc && !eff;
         if (eff) begin
            if (op == OP_START) begin
               m_lim = lim;
               m_rel = rel;
               m_pre = pre;
               m_e   = 0;
               m_st  = M_RUN;
            end else if (op == OP_CLEAR) begin
               m_e  = 0;
               m_st = M_IDLE;
            end else if (op == OP_PAUSE) begin
               m_st = M_PAUSE;
            end else begin
               m_st = M_RUN;
            end
         end else if (m_st == M_RUN) begin
            m_e++;
            if ((m_e % (m_pre + 1)) == 0) begin
               t = m_e / (m_pre + 1);
               if (m_rel != 0) begin
                  if ((t % (m_lim + 1)) == 0) m_done = 1'b1;
               end else if (t == m_lim + 1) begin
                  m_done = 1'b1;
                  m_st   = M_DONE;
               end
            end
         end
         m_rdy = 1'b1;
      end

      @(posedge clk);
      @(negedge clk);

      t  = m_e / (m_pre + 1);
      eq = 0;
      ew = 0;
      if (m_st == M_DONE) begin
         eq = m_lim;
      end else if (m_st != M_IDLE) begin
         if (m_rel != 0) begin
            eq = t % (m_lim + 1);
            ew = t / (m_lim + 1);
            if (ew > 255) ew = 255;
         end else begin
            eq = t;
         end
      end
      chk("q",         int'(bus.q),         eq);
      chk("state",     int'(bus.state),     m_st);
      chk("busy",      int'(bus.busy),      int'((m_st == M_RUN) || (m_st == M_PAUSE)));
      chk("done",      int'(bus.done),      int'(m_done));
      chk("cmd_err",   int'(bus.cmd_err),   int'(m_err));
      chk("wrap_cnt",  int'(bus.wrap_cnt),  ew);
      chk("cmd_ready", int'(bus.cmd_ready), int'(m_rdy));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_START, 0, 0, 0);
   endtask

   task automatic cmd(input logic [1:0] op, input int lim, input int rel, input int pre);
      step(1'b0, 1'b1, op, lim, rel, pre);
   endtask

   initial begin
      bus.cmd_valid    = 1'b0;
      bus.cmd_op       = 2'b00;
      bus.cfg_limit    = '0;
      bus.cfg_reload   = 1'b0;
      bus.cfg_prescale = '0;

      // One-shot, limit 3, no prescale.
      step(1'b1, 1'b0, OP_START, 0, 0, 0);
      chk("rst_ready", int'(bus.cmd_ready), 0);
      chk("rst_state", int'(bus.state), 0);
      idle(1);
      cmd(OP_START, 3, 0, 0);
      idle(3);
      chk("os_q3", int'(bus.q), 3);
      idle(1);
      chk("os_done", int'(bus.done), 1);
      chk("os_state", int'(bus.state), 3);
      idle(1);
      chk("os_done_pulse", int'(bus.done), 0);

      // Reload, limit 2, prescale 1: six clocks per wrap.
      cmd(OP_START, 2, 1, 1);
      idle(18);
      chk("rl_wrap3", int'(bus.wrap_cnt), 3);
      chk("rl_busy", int'(bus.busy), 1);
      idle(2);

      // Pause holds the count; resume picks up where it left off.
      cmd(OP_START, 10, 0, 0);
      idle(5);
      cmd(OP_PAUSE, 0, 0, 0);
      idle(4);
      chk("pz_hold", int'(bus.q), 5);
      cmd(OP_RESUME, 0, 0, 0);
      idle(1);
      chk("pz_resume", int'(bus.q), 6);
      cmd(OP_CLEAR, 0, 0, 0);
      cmd(OP_PAUSE, 0, 0, 0);
      chk("pz_idle_err", int'(bus.cmd_err), 1);
      chk("pz_idle_state", int'(bus.state), 0);

      // Pause on the terminal tick swallows it; done follows after resume.
      cmd(OP_START, 4, 0, 0);
      idle(4);
      cmd(OP_PAUSE, 0, 0, 0);
      chk("pt_q", int'(bus.q), 4);
      chk("pt_done", int'(bus.done), 0);
      chk("pt_state", int'(bus.state), 2);
      cmd(OP_RESUME, 0, 0, 0);
      idle(1);
      chk("pt_done_late", int'(bus.done), 1);

      // Reset in the middle of a reload run.
      cmd(OP_START, 20, 1, 0);
      idle(7);
      chk("mr_q7", int'(bus.q), 7);
      step(1'b1, 1'b0, OP_START, 0, 0, 0);
      chk("mr_q", int'(bus.q), 0);
      chk("mr_ready", int'(bus.cmd_ready), 0);
      idle(1);
      chk("mr_ready_after", int'(bus.cmd_ready), 1);

      // Full-range limit, then wrap counter saturation.
      cmd(OP_START, 255, 1, 0);
      idle(255);
      chk("fl_q255", int'(bus.q), 255);
      idle(1);
      chk("fl_wrap_q", int'(bus.q), 0);
      chk("fl_wrap_done", int'(bus.done), 1);
      idle(300);
      cmd(OP_START, 0, 1, 0);
      idle(300);
      chk("sat_wrap", int'(bus.wrap_cnt), 255);

      // Random commands, configs and occasional resets.
      for (int i = 0; i < 4000; i++) begin
         bit          r_rst;
         bit          r_vld;
         logic [1:0]  r_op;
         int          r_lim;
         int          r_pre;
         r_rst = ($urandom_range(0, 199) == 0);
         r_vld = ($urandom_range(0, 7) == 0);
         r_op  = 2'($urandom_range(0, 3));
         r_lim = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 6);
         r_pre = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
         step(r_rst, r_vld, r_op, r_lim, $urandom_range(0, 1), r_pre);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
